// File: rtl/pcap_replay_pkg.sv
// Shared definitions for the pcap replay stages: gap FSM states, the replay
// queue count and the mapping from a NetFPGA source-port field to a queue.
package pcap_replay_pkg;

  typedef enum logic {
    FSM_PASS = 1'b0,
    FSM_GAP  = 1'b1
  } fsm_e;

  localparam int REPLAY_NUM_QUEUES = 4;
  localparam int REPLAY_QW         = 2;

  // even_bits[i] is src_port[2*i]; the lowest set bit selects the queue,
  // and an all-zero field falls back to queue 0.
  function automatic logic [REPLAY_QW-1:0] src_port_to_queue(
    input logic [REPLAY_NUM_QUEUES-1:0] even_bits
  );
    logic [REPLAY_QW-1:0] q;
    q = '0;
    for (int i = REPLAY_NUM_QUEUES - 1; i >= 0; i--) begin
      if (even_bits[i]) q = REPLAY_QW'(i);
    end
    return q;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream skid buffer with a registered output stage.
// The upstream ready is a register (not combinational from m_ready), and
// the output payload is held steady while m_valid is waiting for m_ready.
module axis_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);

  logic [W-1:0] out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] sk_data_q, sk_data_d;
  logic         sk_valid_q, sk_valid_d;
  logic         s_acc;

  assign s_ready = ~sk_valid_q;
  assign s_acc   = s_valid & ~sk_valid_q;
  assign m_data  = out_data_q;
  assign m_valid = out_valid_q;

  // Next state: refill the output from the skid entry first, else from input.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    sk_data_d   = sk_data_q;
    sk_valid_d  = sk_valid_q;
    if (!out_valid_q || m_ready) begin
      if (sk_valid_q) begin
        out_data_d  = sk_data_q;
        out_valid_d = 1'b1;
        sk_valid_d  = 1'b0;
      end else begin
        out_valid_d = s_acc;
        if (s_acc) out_data_d = s_data;
      end
    end else if (s_acc) begin
      sk_data_d  = s_data;
      sk_valid_d = 1'b1;
    end
  end

  // State registers; the output payload is cleared so reset drives zeros.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sk_valid_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      sk_valid_q  <= sk_valid_d;
      out_data_q  <= out_data_d;
    end
    sk_data_q <= sk_data_d;
  end

endmodule

// File: rtl/pcap_replay_ifg_gate.sv
// Per-queue inter-frame gap gate behind the pcap replay engine.
// After an accepted tlast the input is closed for delay_cfg[q] cycles, where
// q is latched from the tuser source-port field on the packet's first beat.
// Optional feature macro: IFG_GATE_PKT_CNT_EN adds the pkt_count output.
module pcap_replay_ifg_gate
  import pcap_replay_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH    = 256,
  parameter int C_AXIS_TUSER_WIDTH   = 128,
  parameter int C_NUM_QUEUES         = 4,
  parameter int C_SRC_PORT_WIDTH     = 8,
  parameter int C_TUSER_SRC_PORT_POS = 24,
  parameter int C_DELAY_WIDTH        = 32
) (
  input  logic                                   axi_aclk,
  input  logic                                   axi_aresetn,
  input  logic                                   sw_rst,
  input  logic                                   enable,
  input  logic [C_NUM_QUEUES*C_DELAY_WIDTH-1:0]  delay_cfg,
  input  logic [C_AXIS_DATA_WIDTH-1:0]           s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]         s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]          s_axis_tuser,
  input  logic                                   s_axis_tvalid,
  input  logic                                   s_axis_tlast,
  output logic                                   s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]         m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]          m_axis_tuser,
  output logic                                   m_axis_tvalid,
  output logic                                   m_axis_tlast,
  input  logic                                   m_axis_tready
`ifdef IFG_GATE_PKT_CNT_EN
  ,
  output logic [31:0]                            pkt_count
`endif
);

  localparam int PW = C_AXIS_DATA_WIDTH + C_AXIS_DATA_WIDTH/8 + C_AXIS_TUSER_WIDTH + 1;

  logic                         rst_n;
  logic                         skid_ready;
  logic                         s_acc;
  logic [PW-1:0]                m_payload;
  logic [REPLAY_NUM_QUEUES-1:0] even_bits;
  logic [REPLAY_QW-1:0]         q_now, q_eff;
  logic [C_DELAY_WIDTH-1:0]     d_sel;

  fsm_e                     state_q, state_d;
  logic [C_DELAY_WIDTH-1:0] cnt_q, cnt_d;
  logic                     sop_q, sop_d;
  logic [REPLAY_QW-1:0]     q_q, q_d;

  assign rst_n         = axi_aresetn & ~sw_rst;
  assign s_axis_tready = rst_n & (state_q == FSM_PASS) & skid_ready;
  assign s_acc         = s_axis_tvalid & s_axis_tready;

  axis_skid_buf #(.W(PW)) u_skid (
    .clk     (axi_aclk),
    .rst_n   (rst_n),
    .s_data  ({s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tlast}),
    .s_valid (s_acc),
    .s_ready (skid_ready),
    .m_data  (m_payload),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast} = m_payload;

  // Gather src_port[2*i] bits and pick the queue / gap for the current beat.
  always_comb begin
    even_bits = '0;
    for (int i = 0; i < REPLAY_NUM_QUEUES; i++) begin
      if (2 * i < C_SRC_PORT_WIDTH) even_bits[i] = s_axis_tuser[C_TUSER_SRC_PORT_POS + 2*i];
    end
    q_now = src_port_to_queue(even_bits);
    q_eff = sop_q ? q_now : q_q;
    d_sel = delay_cfg[int'(q_eff)*C_DELAY_WIDTH +: C_DELAY_WIDTH];
  end

  // Gap FSM: open in PASS, closed while counting down in GAP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sop_d   = sop_q;
    q_d     = q_q;
    if (s_acc) begin
      sop_d = s_axis_tlast;
      if (sop_q) q_d = q_now;
    end
    case (state_q)
      FSM_PASS: begin
        if (s_acc && s_axis_tlast && enable && (d_sel != '0)) begin
          state_d = FSM_GAP;
          cnt_d   = d_sel;
        end
      end
      FSM_GAP: begin
        cnt_d = cnt_q - C_DELAY_WIDTH'(1);
        if (cnt_q <= C_DELAY_WIDTH'(1)) state_d = FSM_PASS;
      end
      default: state_d = FSM_PASS;
    endcase
  end

  // FSM, gap counter, start-of-packet flag and latched queue.
  always_ff @(posedge axi_aclk) begin
    if (!rst_n) begin
      state_q <= FSM_PASS;
      cnt_q   <= '0;
      sop_q   <= 1'b1;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sop_q   <= sop_d;
      q_q     <= q_d;
    end
  end

`ifdef IFG_GATE_PKT_CNT_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;

  assign pkt_count = pkt_cnt_q;

  // Count packets completed on the output side; wraps naturally.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (m_axis_tvalid && m_axis_tready && m_axis_tlast) pkt_cnt_d = pkt_cnt_q + 32'd1;
  end

  // Packet counter register.
  always_ff @(posedge axi_aclk) begin
    if (!rst_n) pkt_cnt_q <= '0;
    else        pkt_cnt_q <= pkt_cnt_d;
  end
`endif

endmodule

// File: tb/tb_pcap_replay_ifg_gate.sv
// Self-checking bench for pcap_replay_ifg_gate: directed packet sequences with
// random payloads, a scoreboard of accepted beats, and a gap model computed
// from queue selection and sampled enable/delay at each tlast accept.
module tb_pcap_replay_ifg_gate;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int PW = DW + DW/8 + UW + 1;

  logic          clk = 1'b0;
  logic          aresetn, sw_rst, enable;
  logic [127:0]  delay_cfg;
  logic [DW-1:0] s_data;
  logic [DW/8-1:0] s_strb;
  logic [UW-1:0] s_user;
  logic          s_valid, s_last, s_ready;
  logic [DW-1:0] m_data;
  logic [DW/8-1:0] m_strb;
  logic [UW-1:0] m_user;
  logic          m_valid, m_last, m_ready;
`ifdef IFG_GATE_PKT_CNT_EN
  logic [31:0]   pkt_count;
`endif

  pcap_replay_ifg_gate dut (
    .axi_aclk      (clk),
    .axi_aresetn   (aresetn),
    .sw_rst        (sw_rst),
    .enable        (enable),
    .delay_cfg     (delay_cfg),
    .s_axis_tdata  (s_data),
    .s_axis_tstrb  (s_strb),
    .s_axis_tuser  (s_user),
    .s_axis_tvalid (s_valid),
    .s_axis_tlast  (s_last),
    .s_axis_tready (s_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tstrb  (m_strb),
    .m_axis_tuser  (m_user),
    .m_axis_tvalid (m_valid),
    .m_axis_tlast  (m_last),
    .m_axis_tready (m_ready)
`ifdef IFG_GATE_PKT_CNT_EN
    ,
    .pkt_count     (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  longint cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_q(input logic [7:0] sp);
    for (int i = 0; i < 4; i++) if (sp[2*i]) return i;
    return 0;
  endfunction

  function automatic logic [DW-1:0] rand256();
    logic [DW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- reference model / scoreboard ----------------
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] s_payload, m_payload, stall_pl, e;
  assign s_payload = {s_data, s_strb, s_user, s_last};
  assign m_payload = {m_data, m_strb, m_user, m_last};

  bit     exact_mode = 1'b1;
  bit     sop_m, have_last, held, stall_prev;
  int     qm;
  longint last_cyc, gap_d, min_cyc;
  int     pkts_m = 0;

  always @(negedge clk) begin
    if (!aresetn || sw_rst) begin
      exp_q.delete();
      sop_m      = 1'b1;
      have_last  = 1'b0;
      held       = 1'b0;
      stall_prev = 1'b0;
      pkts_m     = 0;
    end else begin
      if (stall_prev) begin
        chk("m_hold_valid", 512'(m_valid), 512'(1'b1));
        chk("m_hold_payload", 512'(m_payload), 512'(stall_pl));
      end
      if (m_valid && m_ready) begin
        chk("m_beat_expected", 512'(exp_q.size() != 0), 512'(1'b1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("m_payload", 512'(m_payload), 512'(e));
        end
        if (m_last) pkts_m++;
      end
      stall_prev = m_valid && !m_ready;
      stall_pl   = m_payload;
      if (!m_ready) held = 1'b0;
      if (s_valid && s_ready) begin
        exp_q.push_back(s_payload);
        if (sop_m) begin
          qm = model_q(s_user[31:24]);
          if (have_last) begin
            min_cyc = last_cyc + 1 + gap_d;
            if (exact_mode && held) chk("gap_exact", 512'(cyc), 512'(min_cyc));
            else                    chk("gap_min", 512'(cyc >= min_cyc), 512'(1'b1));
          end
        end
        if (s_last) begin
          gap_d     = enable ? longint'(delay_cfg[qm*32 +: 32]) : 0;
          last_cyc  = cyc;
          have_last = 1'b1;
          held      = 1'b1;
        end
        sop_m = s_last;
      end else if (!s_valid) begin
        held = 1'b0;
      end
    end
  end

  // ---------------- m-side ready generator ----------------
  bit rand_rdy = 1'b0;
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_accept(output longint acc);
    bit hs = 1'b0;
    int k  = 0;
    acc = -1;
    while (!hs && k < 300) begin
      @(negedge clk);
      hs = s_valid && s_ready;
      if (hs) acc = cyc;
      @(posedge clk);
      #1;
      k++;
    end
    chk("s_accept_in_time", 512'(hs), 512'(1'b1));
  endtask

  task automatic send_pkt(input logic [7:0] src, input int n, input int stop_at,
                          output longint first_acc);
    longint a;
    first_acc = -1;
    for (int b = 0; b < n && b < stop_at; b++) begin
      s_data  = rand256();
      s_strb  = $urandom;
      s_user  = {$urandom, $urandom, $urandom, $urandom};
      s_user[31:24] = src;
      s_last  = (b == n - 1);
      s_valid = 1'b1;
      wait_accept(a);
      if (b == 0) first_acc = a;
    end
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    step(n);
  endtask

  task automatic set_delay(input int q, input logic [31:0] v);
    delay_cfg[q*32 +: 32] = v;
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0] srcs [5];
  longint fa, rel;
  initial begin
    srcs[0] = 8'h01; srcs[1] = 8'h04; srcs[2] = 8'h10; srcs[3] = 8'h40; srcs[4] = 8'h00;
    aresetn = 1'b0; sw_rst = 1'b0; enable = 1'b0; delay_cfg = '0;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_strb = '0; s_user = '0;
    step(3);
    @(negedge clk);
    chk("reset_m_valid", 512'(m_valid), 512'(1'b0));
    chk("reset_s_ready", 512'(s_ready), 512'(1'b0));
    chk("reset_m_tdata", 512'(m_data), 512'(0));
    chk("reset_m_tuser", 512'(m_user), 512'(0));
    @(posedge clk); #1;
    aresetn = 1'b1;
    step(2);

    // two 3-beat packets, q0 gap 5
    enable = 1'b1; set_delay(0, 32'd5);
    send_pkt(8'h01, 3, 99, fa);
    send_pkt(8'h01, 3, 99, fa);
    idle(10);

    // bypass: one-beat packets every cycle despite large delay
    enable = 1'b0; set_delay(0, 32'd100);
    for (int p = 0; p < 6; p++) send_pkt(8'h01, 1, 99, fa);
    idle(5);

    // per-queue gaps 1,2,3,4 and the 0x00 fallback to q0
    enable = 1'b1;
    set_delay(0, 32'd1); set_delay(1, 32'd2); set_delay(2, 32'd3); set_delay(3, 32'd4);
    for (int p = 0; p < 5; p++) send_pkt(srcs[p], 2, 99, fa);
    send_pkt(8'h01, 1, 99, fa);
    idle(10);

    // clearing enable inside a gap keeps that gap, removes the next one
    set_delay(0, 32'd8);
    send_pkt(8'h01, 2, 99, fa);
    enable = 1'b0;
    send_pkt(8'h01, 2, 99, fa);
    send_pkt(8'h01, 1, 99, fa);
    idle(12);

    // random backpressure with random small gaps
    enable = 1'b1; exact_mode = 1'b0; rand_rdy = 1'b1;
    for (int p = 0; p < 3; p++) begin
      for (int q = 0; q < 4; q++) set_delay(q, 32'($urandom_range(0, 6)));
      send_pkt(srcs[$urandom_range(0, 4)], $urandom_range(1, 4), 99, fa);
    end
    idle(40);
    rand_rdy = 1'b0; exact_mode = 1'b1;
    idle(10);

    // sw_rst in the middle of a packet
    set_delay(0, 32'd50);
    send_pkt(8'h01, 3, 2, fa);
    s_valid = 1'b0;
    sw_rst  = 1'b1;
    @(negedge clk);
    chk("swrst_s_ready_low", 512'(s_ready), 512'(1'b0));
    @(posedge clk); #1;
    sw_rst = 1'b0;
    chk("swrst_pkt_m_valid", 512'(m_valid), 512'(1'b0));
    chk("swrst_pkt_m_tdata", 512'(m_data), 512'(0));
    rel = cyc;
    send_pkt(8'h04, 2, 99, fa);
    chk("swrst_pkt_next_accept", 512'(fa), 512'(rel));
    idle(5);

    // sw_rst in the middle of a 50-cycle gap
    send_pkt(8'h01, 2, 99, fa);
    idle(10);
    chk("gap_holds_s_ready", 512'(s_ready), 512'(1'b0));
    sw_rst = 1'b1;
    step(1);
    sw_rst = 1'b0;
    chk("swrst_gap_m_valid", 512'(m_valid), 512'(1'b0));
    rel = cyc;
    send_pkt(8'h01, 1, 99, fa);
    chk("swrst_gap_next_accept", 512'(fa), 512'(rel));
    idle(5);
    for (int p = 0; p < 6; p++) begin
      enable = 1'b0;
      send_pkt(8'h10, 1, 99, fa);
    end
    idle(10);

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) step(1);
    chk("scoreboard_drained", 512'(exp_q.size()), 512'(0));
`ifdef IFG_GATE_PKT_CNT_EN
    chk("pkt_count", 512'(pkt_count), 512'(pkts_m));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
